// File: rtl/board_input_pkg.sv
// Shared constants for the board input controller.
//   ADDR_*        : Avalon-MM word addresses of the four registers
//   INFO_ID       : identifier reported in INFO[31:16]
//   N_*_DEFAULT   : default pushbutton / switch counts for the DE1-SoC
package board_input_pkg;

    localparam int N_KEY_DEFAULT = 4;
    localparam int N_SW_DEFAULT  = 10;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_INFO = 2'd3;

    localparam logic [15:0] INFO_ID = 16'h1D0C;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser and debouncer.
//   clk, reset : system clock, synchronous active-high reset
//   din        : raw asynchronous input, already active-high
//   deb        : debounced value
//   toggle     : high in the cycle whose clock edge flips deb
//                (the new value of deb is ~deb)
// deb only follows the synchronised input after it has differed from deb
// for DEBOUNCE_CYCLES consecutive cycles. Any return to the current deb
// value restarts the count, so shorter glitches are ignored.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic deb,
    output logic toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign deb    = deb_reg;
    assign toggle = (sync2_reg != deb_reg) && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                deb_reg <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_input_ctrl.sv
// DE1-SoC KEY/SW input stage with an Avalon-MM slave for the Nios.
//   clk, reset      : system clock, synchronous active-high reset
//   key_n           : raw pushbuttons, 0 = pressed
//   sw              : raw slider switches, 1 = on
//   avs_address     : register word address (DATA, EDGE, MASK, INFO)
//   avs_read/write  : bus strobes; avs_writedata write data
//   avs_readdata    : read data, valid the cycle after avs_read
//   irq             : level interrupt, |(EDGE & MASK)
// Bit order everywhere is {sw, key}: keys in the low N_KEY bits.
module board_input_ctrl
    import board_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int N_KEY           = N_KEY_DEFAULT,
    parameter int N_SW            = N_SW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEY-1:0]  key_n,
    input  logic [N_SW-1:0]   sw,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    localparam int N_IN = N_KEY + N_SW;

    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] deb_bits;
    logic [N_IN-1:0] toggle_bits;
    logic [N_IN-1:0] edge_set;

    logic [N_IN-1:0] edge_reg, edge_next;
    logic [N_IN-1:0] mask_reg, mask_next;
    logic [31:0]     readdata_reg, readdata_next;

    logic [N_IN-1:0] edge_clr;
    logic [31:0]     data_word;
    logic [31:0]     edge_word;
    logic [31:0]     mask_word;
    logic [31:0]     info_word;
    logic            unused_wd;

    // Keys are inverted before synchronising so a press is a 0->1 change.
    assign raw_in = {sw, ~key_n};

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .din    (raw_in[gi]),
                .deb    (deb_bits[gi]),
                .toggle (toggle_bits[gi])
            );

            // Keys report presses only; switches report both directions.
            if (gi < N_KEY) begin : g_key_evt
                assign edge_set[gi] = toggle_bits[gi] & ~deb_bits[gi];
            end else begin : g_sw_evt
                assign edge_set[gi] = toggle_bits[gi];
            end
        end
    endgenerate

    assign unused_wd = ^avs_writedata[31:N_IN];

    always_comb begin
        data_word = '0;
        edge_word = '0;
        mask_word = '0;
        data_word[N_IN-1:0] = deb_bits;
        edge_word[N_IN-1:0] = edge_reg;
        mask_word[N_IN-1:0] = mask_reg;
    end

    assign info_word = {INFO_ID, 8'h00, 8'(N_IN)};

    always_comb begin
        edge_clr      = '0;
        mask_next     = mask_reg;
        readdata_next = readdata_reg;

        if (avs_write && avs_address == ADDR_EDGE) begin
            edge_clr = avs_writedata[N_IN-1:0];
        end
        if (avs_write && avs_address == ADDR_MASK) begin
            mask_next = avs_writedata[N_IN-1:0];
        end

        // A new event wins over a simultaneous write-1-to-clear.
        edge_next = (edge_reg & ~edge_clr) | edge_set;

        // Read mux uses current register values, so a read paired with a
        // write returns the pre-write contents.
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA: readdata_next = data_word;
                ADDR_EDGE: readdata_next = edge_word;
                ADDR_MASK: readdata_next = mask_word;
                default:   readdata_next = info_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_reg     <= '0;
            mask_reg     <= '0;
            readdata_reg <= '0;
        end else begin
            edge_reg     <= edge_next;
            mask_reg     <= mask_next;
            readdata_reg <= readdata_next;
        end
    end

    assign avs_readdata = readdata_reg;
    assign irq          = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_board_input_ctrl.sv
// Self-checking bench for board_input_ctrl with DEBOUNCE_CYCLES = 4.
// Inputs are driven on the falling edge; outputs are sampled on the
// falling edge, half a period away from the active rising edge.
module tb_board_input_ctrl;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_INFO = 2'd3;

    logic        clk;
    logic        reset;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        bit          do_wr;
        logic [1:0]  wr_addr;
        logic [31:0] wr_data;
        logic [1:0]  rd_addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[11];

    board_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .N_KEY           (4),
        .N_SW            (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .sw            (sw),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue a read; the expected value goes to the scoreboard and is
    // compared when readdata becomes valid one cycle later.
    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        avs_address = addr;
        avs_read    = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        avs_read = 1'b0;
        $display("rd  %-20s addr=%0d data=%h", name, addr, avs_readdata);
        check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        $display("wr  addr=%0d data=%h", addr, data);
    endtask

    function automatic vec_t mk(input bit do_wr, input logic [1:0] wa, input logic [31:0] wd,
                                input logic [1:0] ra, input logic [31:0] er);
        vec_t v;
        v.do_wr   = do_wr;
        v.wr_addr = wa;
        v.wr_data = wd;
        v.rd_addr = ra;
        v.exp_rd  = er;
        v.exp_irq = 1'b0;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1'b0, A_DATA, 32'h0,         A_INFO, 32'h1D0C_000E);
        vecs[1]  = mk(1'b0, A_DATA, 32'h0,         A_DATA, 32'h0);
        vecs[2]  = mk(1'b0, A_DATA, 32'h0,         A_EDGE, 32'h0);
        vecs[3]  = mk(1'b0, A_DATA, 32'h0,         A_MASK, 32'h0);
        vecs[4]  = mk(1'b1, A_MASK, 32'h0000_3FFF, A_MASK, 32'h0000_3FFF);
        vecs[5]  = mk(1'b1, A_MASK, 32'hFFFF_FFFF, A_MASK, 32'h0000_3FFF);
        vecs[6]  = mk(1'b1, A_MASK, 32'h0000_2A55, A_MASK, 32'h0000_2A55);
        vecs[7]  = mk(1'b1, A_DATA, 32'hFFFF_FFFF, A_DATA, 32'h0);
        vecs[8]  = mk(1'b1, A_INFO, 32'h0,         A_INFO, 32'h1D0C_000E);
        vecs[9]  = mk(1'b1, A_EDGE, 32'hFFFF_FFFF, A_EDGE, 32'h0);
        vecs[10] = mk(1'b1, A_MASK, 32'h0,         A_MASK, 32'h0);

        reset         = 1'b1;
        key_n         = 4'hF;
        sw            = 10'h0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;

        // Reset held for three rising edges.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("irq_after_reset", {31'h0, irq}, 32'h0);

        // Register map and reset state from the table.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wr_data);
            bus_read(vecs[i].rd_addr, vecs[i].exp_rd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // key[0] press: DATA[0] must flip exactly 6 cycles after the pin edge.
        key_n[0] = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(A_DATA, 32'h0, "key0_deb_cyc5");
        bus_read(A_DATA, 32'h1, "key0_deb_cyc6");
        bus_read(A_EDGE, 32'h1, "key0_edge");
        check("key0_irq_masked", {31'h0, irq}, 32'h0);

        // 3-cycle glitch on key[1] must be rejected.
        key_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        key_n[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_read(A_DATA, 32'h1, $sformatf("glitch_data%0d", i));
            bus_read(A_EDGE, 32'h1, $sformatf("glitch_edge%0d", i));
        end

        // sw[0] change with MASK[4]: irq rises 6 cycles after the pin edge.
        bus_write(A_MASK, 32'h0000_0010);
        check("sw0_irq_pre", {31'h0, irq}, 32'h0);
        sw[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("sw0_irq_cyc%0d", k), {31'h0, irq}, {31'h0, (k == 6)});
        end
        bus_read(A_EDGE, 32'h11, "sw0_edge");
        bus_read(A_DATA, 32'h11, "sw0_data");
        bus_write(A_EDGE, 32'h0000_0010);
        check("sw0_w1c_irq", {31'h0, irq}, 32'h0);
        bus_read(A_EDGE, 32'h1, "sw0_w1c_edge");

        // Key release produces no event.
        bus_write(A_EDGE, 32'h0000_3FFF);
        bus_read(A_EDGE, 32'h0, "edge_cleared");
        key_n[0] = 1'b1;
        repeat (8) @(negedge clk);
        bus_read(A_DATA, 32'h10, "key0_release_data");
        bus_read(A_EDGE, 32'h0, "key0_release_edge");

        // W1C on the same edge as a key[0] press event: set wins.
        bus_write(A_MASK, 32'h0000_0001);
        key_n[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("collide_irq_pre", {31'h0, irq}, 32'h0);
        bus_write(A_EDGE, 32'h0000_0001);
        check("collide_irq", {31'h0, irq}, 32'h1);
        bus_read(A_EDGE, 32'h1, "collide_edge");
        bus_write(A_EDGE, 32'h0000_0001);
        check("collide_clear_irq", {31'h0, irq}, 32'h0);

        // Read and write MASK together: read returns the pre-write value.
        avs_address   = A_MASK;
        avs_writedata = 32'h0000_0ABC;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        exp_q.push_back(32'h1);
        name_q.push_back("rw_same_cycle");
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        $display("rdwr addr=%0d data=%h", A_MASK, avs_readdata);
        check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
        bus_read(A_MASK, 32'h0000_0ABC, "rw_mask_after");
        bus_write(A_MASK, 32'h0);

        // Reset in the middle of a sw[3] count aborts it.
        key_n[0] = 1'b1;
        sw[0]    = 1'b0;
        repeat (8) @(negedge clk);
        sw[3] = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_EDGE, 32'h0, "abort_edge0");
        for (int k = 1; k <= 5; k++) begin
            bus_read(A_DATA, 32'h0, $sformatf("abort_data%0d", k));
        end
        bus_read(A_DATA, 32'h80, "abort_data6");
        bus_read(A_EDGE, 32'h80, "abort_new_edge");
        bus_read(A_MASK, 32'h0, "abort_mask");
        check("abort_irq", {31'h0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
